output_port_arbiter: RTL and testbench

Per-output-port wormhole arbiter/switch sitting directly downstream of the node's input FIFOs. It selects one input buffer whose head flit is routed to this port and forwards that packet's flits to the output converter. It holds the port until the whole packet (length taken from the head flit) has passed, then re-arbitrates round-robin. One instance per output port replaces the per-port MUX plus controller logic in the node.

---
 rtl/noc_pkg.sv | 23 ++
 rtl/output_port_arbiter_rr_pick.sv | 26 ++
 rtl/output_port_arbiter.sv | 101 ++++++++++
 tb/tb_output_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC types: flit width, head-flit layout and arbiter state encoding.
package noc_pkg;

  localparam int FLIT_W = 16;

  typedef struct packed {
    logic [7:0] len;
    logic [7:0] addr;
  } flit_head_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Packet length in flits (head included) carried by a head flit.
  function automatic logic [7:0] head_len(input logic [15:0] flit);
    flit_head_t h;
    h = flit;
    return h.len;
  endfunction

endpackage

// File: rtl/output_port_arbiter_rr_pick.sv
// Round-robin picker: first requester at or above ptr, wrapping upward.
module rr_pick #(
  parameter int NUM_IN = 3,
  parameter int PW     = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic              found,
  output logic [PW-1:0]     idx
);

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_IN]) begin
        found = 1'b1;
        idx   = PW'((int'(ptr) + k) % NUM_IN);
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port wormhole switch: grants one input round-robin and holds
// the port until the packet length announced by its head flit has passed.
import noc_pkg::*;

module output_port_arbiter #(
  parameter int NUM_IN = 3,
  parameter int FLIT_W = noc_pkg::FLIT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN*FLIT_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_route,
  output logic [NUM_IN-1:0]        in_pop,
  input  logic                     out_full,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_data,
  output logic [NUM_IN-1:0]        grant,
  output logic                     busy
);

  localparam int PW = $clog2(NUM_IN);

  arb_state_e        r_state, w_state_next;
  logic [PW-1:0]     r_owner, w_owner_next;
  logic [PW-1:0]     r_rr_ptr, w_rr_ptr_next;
  logic [7:0]        r_remaining, w_remaining_next;

  logic [NUM_IN-1:0] w_req, w_pick_gnt, w_owner_oh, w_sel_oh;
  logic [PW-1:0]     w_pick_idx, w_sel_idx;
  logic              w_pick_found, w_locked, w_sel_valid, w_xfer;
  logic [FLIT_W-1:0] w_sel_data;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (int'(i) == NUM_IN - 1) ? '0 : i + 1'b1;
  endfunction

  assign w_req = in_valid & in_route;

  rr_pick #(.NUM_IN(NUM_IN), .PW(PW)) u_rr_pick (
    .req   (w_req),
    .ptr   (r_rr_ptr),
    .gnt   (w_pick_gnt),
    .found (w_pick_found),
    .idx   (w_pick_idx)
  );

  // Routing is only consulted while idle; a locked port follows its owner.
  assign w_locked    = (r_state == LOCKED);
  assign w_owner_oh  = NUM_IN'(1) << r_owner;
  assign w_sel_idx   = w_locked ? r_owner : w_pick_idx;
  assign w_sel_oh    = w_locked ? w_owner_oh : w_pick_gnt;
  assign w_sel_valid = w_locked ? in_valid[r_owner] : w_pick_found;
  assign w_sel_data  = in_data[w_sel_idx*FLIT_W +: FLIT_W];
  assign w_xfer      = rst & w_sel_valid & ~out_full;

  assign out_valid = w_xfer;
  assign in_pop    = w_xfer ? w_sel_oh : '0;
  assign grant     = rst ? w_sel_oh : '0;
  assign out_data  = rst ? w_sel_data : '0;
  assign busy      = rst & w_locked;

  always_comb begin
    w_state_next     = r_state;
    w_owner_next     = r_owner;
    w_remaining_next = r_remaining;
    w_rr_ptr_next    = r_rr_ptr;
    if (w_xfer) begin
      if (!w_locked) begin
        if (head_len(w_sel_data[15:0]) <= 8'd1) begin
          w_rr_ptr_next = next_idx(w_pick_idx);
        end else begin
          w_state_next     = LOCKED;
          w_owner_next     = w_pick_idx;
          w_remaining_next = head_len(w_sel_data[15:0]) - 8'd1;
        end
      end else begin
        w_remaining_next = r_remaining - 8'd1;
        if (r_remaining == 8'd1) begin
          w_state_next  = IDLE;
          w_rr_ptr_next = next_idx(r_owner);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_remaining <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_owner     <= w_owner_next;
      r_remaining <= w_remaining_next;
      r_rr_ptr    <= w_rr_ptr_next;
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: FIFO-backed directed traffic, a packet-level
// reference model checked every cycle, and literal expectations per scenario.
module tb_output_port_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  in_valid;
  logic [47:0] in_data;
  logic [2:0]  in_route;
  logic [2:0]  in_pop;
  logic        out_full;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  grant;
  logic        busy;

  output_port_arbiter #(.NUM_IN(3), .FLIT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_route  (in_route),
    .in_pop    (in_pop),
    .out_full  (out_full),
    .out_valid (out_valid),
    .out_data  (out_data),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] q[3][$];
  logic [2:0]  hold;
  logic [2:0]  route;
  logic        full;
  logic [18:0] log_q[$];

  // Reference model: packet owner (-1 when free), flits still owed, next priority.
  int m_owner = -1;
  int m_left  = 0;
  int m_rr    = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_log(string name, int k, logic [2:0] p, logic [15:0] d);
    if (k < log_q.size()) chk(name, 32'(log_q[k]), 32'({p, d}));
    else                  chk(name, 32'hFFFF_FFFF, 32'({p, d}));
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      in_valid[i]         = (q[i].size() > 0) && !hold[i];
      in_data[i*16 +: 16] = (q[i].size() > 0) ? q[i][0] : 16'h0000;
      in_route[i]         = route[i];
    end
    out_full = full;
  endtask

  task automatic cycle();
    logic [2:0] snap;
    drive();
    @(negedge clk);
    snap = in_pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      if (snap[i] && q[i].size() > 0) void'(q[i].pop_front());
    drive();
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [2:0] eg;
    logic       ev;
    logic       eb;
    int         w;
    int         len;
    if (!rst) begin
      m_owner = -1;
      m_left  = 0;
      m_rr    = 0;
      chk("rst_pop",   32'(in_pop),    0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_grant", 32'(grant),     0);
      chk("rst_busy",  32'(busy),      0);
      chk("rst_data",  32'(out_data),  0);
    end else begin
      w = -1;
      if (m_owner < 0) begin
        for (int k = 0; k < 3; k++)
          if (w < 0 && in_valid[(m_rr + k) % 3] && in_route[(m_rr + k) % 3]) w = (m_rr + k) % 3;
        eg = (w >= 0) ? 3'(1 << w) : 3'b000;
        ev = (w >= 0) && !out_full;
        eb = 1'b0;
      end else begin
        w  = m_owner;
        eg = 3'(1 << w);
        ev = in_valid[w] && !out_full;
        eb = 1'b1;
      end
      chk("grant",     32'(grant),     32'(eg));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("in_pop",    32'(in_pop),    ev ? 32'(eg) : 0);
      chk("busy",      32'(busy),      32'(eb));
      if (ev) begin
        chk("out_data", 32'(out_data), 32'(in_data[w*16 +: 16]));
        if (m_owner < 0) begin
          len = int'(in_data[w*16 + 8 +: 8]);
          if (len <= 1) m_rr = (w + 1) % 3;
          else begin
            m_owner = w;
            m_left  = len - 1;
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_rr    = (m_owner + 1) % 3;
            m_owner = -1;
          end
        end
      end
    end
    if (out_valid) begin
      log_q.push_back({in_pop, out_data});
      $display("xfer t=%0t pop=%b data=%h busy=%b", $time, in_pop, out_data, busy);
    end
  end

  initial begin
    rst   = 1'b0;
    hold  = 3'b000;
    route = 3'b111;
    full  = 1'b0;
    drive();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: single-flit packet from input 0
    log_q.delete();
    q[0].push_back(16'h0112);
    cycles(2);
    chk("t1_n", log_q.size(), 1);
    exp_log("t1_0", 0, 3'b001, 16'h0112);

    // 2: 4-flit wormhole on input 1 while input 0 keeps requesting
    log_q.delete();
    q[0].push_back(16'h0110); q[0].push_back(16'h0113);
    q[1].push_back(16'h0421); q[1].push_back(16'hA001);
    q[1].push_back(16'hA002); q[1].push_back(16'hA003);
    cycles(7);
    chk("t2_n", log_q.size(), 6);
    exp_log("t2_0", 0, 3'b010, 16'h0421);
    exp_log("t2_1", 1, 3'b010, 16'hA001);
    exp_log("t2_2", 2, 3'b010, 16'hA002);
    exp_log("t2_3", 3, 3'b010, 16'hA003);
    exp_log("t2_4", 4, 3'b001, 16'h0110);
    exp_log("t2_5", 5, 3'b001, 16'h0113);

    // 3: round-robin from reset with all inputs busy
    do_reset();
    log_q.delete();
    q[0].push_back(16'h0100); q[0].push_back(16'h0103);
    q[1].push_back(16'h0101); q[1].push_back(16'h0104);
    q[2].push_back(16'h0102); q[2].push_back(16'h0105);
    cycles(7);
    chk("t3_n", log_q.size(), 6);
    exp_log("t3_0", 0, 3'b001, 16'h0100);
    exp_log("t3_1", 1, 3'b010, 16'h0101);
    exp_log("t3_2", 2, 3'b100, 16'h0102);
    exp_log("t3_3", 3, 3'b001, 16'h0103);

    // Input 2 valid but routed elsewhere must be ignored
    log_q.delete();
    route = 3'b011;
    q[2].push_back(16'h0130);
    q[0].push_back(16'h0131);
    cycles(2);
    chk("rt_n", log_q.size(), 1);
    exp_log("rt_0", 0, 3'b001, 16'h0131);
    chk("rt_left", q[2].size(), 1);
    q[2].delete();
    route = 3'b111;

    // 4: backpressure on the 3rd flit for 5 cycles
    log_q.delete();
    q[1].push_back(16'h0422); q[1].push_back(16'hB001);
    q[1].push_back(16'hB002); q[1].push_back(16'hB003);
    cycles(2);
    full = 1'b1;
    cycles(5);
    chk("t4_rem", 32'(dut.r_remaining), 2);
    full = 1'b0;
    cycles(3);
    chk("t4_n", log_q.size(), 4);
    exp_log("t4_0", 0, 3'b010, 16'h0422);
    exp_log("t4_1", 1, 3'b010, 16'hB001);
    exp_log("t4_2", 2, 3'b010, 16'hB002);
    exp_log("t4_3", 3, 3'b010, 16'hB003);

    // 5: owner bubble while another input waits
    log_q.delete();
    q[2].push_back(16'h0323); q[2].push_back(16'hC001); q[2].push_back(16'hC002);
    q[0].push_back(16'h0133);
    cycle();
    hold = 3'b100;
    cycles(2);
    hold = 3'b000;
    cycles(3);
    chk("t5_n", log_q.size(), 4);
    exp_log("t5_0", 0, 3'b100, 16'h0323);
    exp_log("t5_1", 1, 3'b100, 16'hC001);
    exp_log("t5_2", 2, 3'b100, 16'hC002);
    exp_log("t5_3", 3, 3'b001, 16'h0133);

    // 6: asynchronous reset mid-packet
    log_q.delete();
    q[1].push_back(16'h0424); q[1].push_back(16'hD001);
    q[1].push_back(16'hD002); q[1].push_back(16'hD003);
    q[0].push_back(16'h0134);
    cycles(2);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_pop",   32'(in_pop),    0);
    chk("t6_busy",  32'(busy),      0);
    chk("t6_grant", 32'(grant),     0);
    q[1].delete();
    drive();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q[2].push_back(16'h0135);
    cycles(3);
    chk("t6_n", log_q.size(), 4);
    exp_log("t6_0", 0, 3'b010, 16'h0424);
    exp_log("t6_1", 1, 3'b010, 16'hD001);
    exp_log("t6_2", 2, 3'b001, 16'h0134);
    exp_log("t6_3", 3, 3'b100, 16'h0135);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
